ram_port1_arbiter: RTL

- Shares port 1 of the dual-port byte-write-enable data RAM between two requesters: A = load/store unit (LSU), B = program/data loader.
- Port 0 stays dedicated to instruction fetch and is not touched by this block.
- Single-cycle accesses: the RAM reads asynchronously and writes synchronously. The block registers read data into a one-cycle-later response.
- Arbitration is round-robin. B can additionally lock the port for bounded bursts.

---
 rtl/ram_port1_arbiter_if.sv | 25 ++
 rtl/ram_port1_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ram_port1_arbiter_if.sv
// Request/response bundle between one requester and the RAM port-1 arbiter.
// The requester holds the master modport; the arbiter holds the slave modport.
interface ram_port1_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
);
    logic                  valid;
    logic                  ready;
    logic [AWIDTH-1:0]     addr;
    logic                  wen;
    logic [DWIDTH/8-1:0]   wbe;
    logic [DWIDTH-1:0]     wdata;
    logic                  rvalid;
    logic [DWIDTH-1:0]     rdata;

    modport master (
        output valid, addr, wen, wbe, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wbe, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/ram_port1_arbiter.sv
// Round-robin arbiter sharing RAM port 1 between the LSU (A) and the loader (B).
// B may lock the port for bursts of up to MAX_LOCK beats; idle lock cycles go to A.
module ram_port1_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 14,
    parameter int MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_port1_arbiter_if.slave   a,
    ram_port1_arbiter_if.slave   b,
    input  logic                 b_lock,
    output logic [AWIDTH-1:0]    ram_addr,
    output logic                 ram_wen,
    output logic [DWIDTH/8-1:0]  ram_wbe,
    output logic [DWIDTH-1:0]    ram_d,
    input  logic [DWIDTH-1:0]    ram_q
);
    localparam int CW = $clog2(MAX_LOCK) + 1;

    typedef enum logic {ST_RR, ST_LOCK_B} state_t;

    state_t          state, state_n;
    logic            prio, prio_n;
    logic [CW-1:0]   lock_cnt, lock_cnt_n;
    logic            grant_a, grant_b;

    logic              a_rvalid_p1, b_rvalid_p1;
    logic [DWIDTH-1:0] a_rdata_p1, b_rdata_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RR;
            prio     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_n;
            prio     <= prio_n;
            lock_cnt <= lock_cnt_n;
        end
    end

    // Grants are gated by rst so nothing reaches the RAM while reset is held.
    always_comb begin
        state_n    = state;
        prio_n     = prio;
        lock_cnt_n = lock_cnt;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        if (!rst) begin
            case (state)
                ST_RR: begin
                    if (a.valid && b.valid) begin
                        grant_a = !prio;
                        grant_b = prio;
                    end else begin
                        grant_a = a.valid;
                        grant_b = b.valid;
                    end
                    if (grant_a) prio_n = 1'b1;
                    if (grant_b) begin
                        prio_n = 1'b0;
                        if (b_lock) begin
                            state_n    = ST_LOCK_B;
                            lock_cnt_n = CW'(1);
                        end
                    end
                end
                ST_LOCK_B: begin
                    grant_b = b.valid;
                    grant_a = a.valid && !b.valid;
                    if (grant_b) begin
                        if (!b_lock || lock_cnt == CW'(MAX_LOCK - 1)) begin
                            state_n    = ST_RR;
                            prio_n     = 1'b0;
                            lock_cnt_n = '0;
                        end else begin
                            lock_cnt_n = lock_cnt + CW'(1);
                        end
                    end
                end
                default: state_n = ST_RR;
            endcase
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_wen  = 1'b0;
        ram_wbe  = '0;
        ram_d    = '0;
        if (grant_a) begin
            ram_addr = a.addr;
            ram_wen  = a.wen;
            ram_wbe  = a.wbe;
            ram_d    = a.wdata;
        end else if (grant_b) begin
            ram_addr = b.addr;
            ram_wen  = b.wen;
            ram_wbe  = b.wbe;
            ram_d    = b.wdata;
        end
    end

    // Response stage: one-cycle pulse per accepted beat, read data captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid_p1 <= 1'b0;
            b_rvalid_p1 <= 1'b0;
            a_rdata_p1  <= '0;
            b_rdata_p1  <= '0;
        end else begin
            a_rvalid_p1 <= grant_a;
            b_rvalid_p1 <= grant_b;
            if (grant_a && !a.wen) a_rdata_p1 <= ram_q;
            if (grant_b && !b.wen) b_rdata_p1 <= ram_q;
        end
    end

    assign a.ready  = grant_a;
    assign b.ready  = grant_b;
    assign a.rvalid = a_rvalid_p1;
    assign b.rvalid = b_rvalid_p1;
    assign a.rdata  = a_rdata_p1;
    assign b.rdata  = b_rdata_p1;
endmodule
